// File: rtl/mc_control.sv
// mc_control: multicycle fetch/decode/execute/memory/write-back sequencer.
// Revision 1.0
`default_nettype none

module mc_control #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             tgt_we,
   output logic             alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic [1:0]       alu_op,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   state_t        cur, nxt;
   logic [TW-1:0] tcnt;
   logic          retire, set_ill, set_berr;
   logic          is_load, is_ialu, is_store, is_branch, is_rtype;
   logic          decode_ok, taken, timeout;

   // funct7_5 feeds the ALU decoder directly; nothing here depends on it
   logic unused_funct7_5;
   assign unused_funct7_5 = funct7_5;

   assign is_load   = (opcode == OP_LOAD);
   assign is_ialu   = (opcode == OP_IALU);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_rtype  = (opcode == OP_RTYPE);
   assign decode_ok = is_load | is_ialu | is_store | is_rtype |
                      (is_branch && (funct3[2:1] != 2'b01));
   assign timeout   = (tcnt == TW'(MEM_TIMEOUT - 1)) && !mem_ready;
   assign state     = cur;

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = alu_zero;
         3'b001:  taken = !alu_zero;
         3'b100:  taken = alu_lt;
         3'b101:  taken = !alu_lt;
         3'b110:  taken = alu_ltu;
         3'b111:  taken = !alu_ltu;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      nxt          = cur;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      tgt_we       = 1'b0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 2'd0;
      alu_op       = 2'b00;
      reg_we       = 1'b0;
      wb_sel       = 1'b0;
      retire       = 1'b0;
      set_ill      = 1'b0;
      set_berr     = 1'b0;
      case (cur)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
               nxt   = S_DECODE;
            end else if (timeout) begin
               set_berr = 1'b1;
               nxt      = S_TRAP;
            end
         end
         S_DECODE: begin
            // speculative branch target: old PC + immediate
            alu_a_sel = 1'b1;
            alu_b_sel = 2'd1;
            tgt_we    = 1'b1;
            if (decode_ok) begin
               nxt = S_EXEC;
            end else begin
               set_ill = 1'b1;
               nxt     = S_TRAP;
            end
         end
         S_EXEC: begin
            if (is_load || is_store) begin
               alu_b_sel = 2'd1;
               nxt       = S_MEM;
            end else if (is_ialu) begin
               alu_b_sel = 2'd1;
               alu_op    = 2'b10;
               nxt       = S_WB;
            end else if (is_rtype) begin
               alu_op = 2'b10;
               nxt    = S_WB;
            end else begin
               alu_op = 2'b01;
               pc_we  = taken;
               pc_src = taken;
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  retire = 1'b1;
                  nxt    = S_FETCH;
               end else begin
                  mdr_we = 1'b1;
                  nxt    = S_WB;
               end
            end else if (timeout) begin
               set_berr = 1'b1;
               nxt      = S_TRAP;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_sel = is_load;
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         S_TRAP:  nxt = S_TRAP;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_IDLE;
         tcnt    <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
         instret <= '0;
      end else begin
         cur <= nxt;
         // counter only runs while a memory state is stalled; any other cycle clears it
         if ((cur == S_FETCH || cur == S_MEM) && !mem_ready && !timeout)
            tcnt <= tcnt + TW'(1);
         else
            tcnt <= '0;
         if (set_ill)
            illegal <= 1'b1;
         if (set_berr)
            bus_err <= 1'b1;
         if (retire)
            instret <= instret + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven and directed checks for mc_control.
`default_nettype none

module tb_mc_control;

   logic       clk, rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, alu_zero, alu_lt, alu_ltu, mem_ready;
   logic       mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src, tgt_we;
   logic       alu_a_sel, reg_we, wb_sel, illegal, bus_err;
   logic [1:0] alu_b_sel, alu_op;
   logic [2:0] state;
   logic [3:0] instret;
   logic [14:0] ctrl;

   int checks = 0;
   int errors = 0;

   mc_control #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
      .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src), .tgt_we(tgt_we),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .reg_we(reg_we),
      .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .state(state),
      .instret(instret)
   );

   assign ctrl = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_src, tgt_we,
                  alu_a_sel, alu_b_sel, alu_op, reg_we, wb_sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        z, lt, ltu, rdy;
      logic [2:0]  st;
      logic [14:0] ctl;
      logic [1:0]  fl;   // {illegal, bus_err}
      logic [3:0]  ret;
   } vec_t;

   vec_t vt[$];

   function automatic logic [14:0] cv(input logic mreq, mwe, masel, irwe, mdrwe, pcwe,
                                      pcsrc, tgtwe, asel, input logic [1:0] bsel, aop,
                                      input logic rwe, wbs);
      return {mreq, mwe, masel, irwe, mdrwe, pcwe, pcsrc, tgtwe, asel, bsel, aop, rwe, wbs};
   endfunction

   function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                               input logic z, lt, ltu, rdy, input logic [2:0] st,
                               input logic [14:0] ctl, input logic [1:0] fl,
                               input logic [3:0] ret);
      vec_t v;
      v.op = op; v.f3 = f3; v.z = z; v.lt = lt; v.ltu = ltu; v.rdy = rdy;
      v.st = st; v.ctl = ctl; v.fl = fl; v.ret = ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after a falling edge, check, then advance one cycle
   task automatic step(input vec_t v, input string tag, input int idx);
      opcode = v.op; funct3 = v.f3; alu_zero = v.z; alu_lt = v.lt; alu_ltu = v.ltu;
      mem_ready = v.rdy;
      #1;
      chk($sformatf("%s[%0d] state", tag, idx), 32'(state), 32'(v.st));
      chk($sformatf("%s[%0d] ctrl", tag, idx), 32'(ctrl), 32'(v.ctl));
      chk($sformatf("%s[%0d] flags", tag, idx), 32'({illegal, bus_err}), 32'(v.fl));
      chk($sformatf("%s[%0d] instret", tag, idx), 32'(instret), 32'(v.ret));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   localparam logic [6:0] LD = 7'h03, AI = 7'h13, STO = 7'h23, BR = 7'h63, RT = 7'h33;

   initial begin
      logic [14:0] C0, F_R, F_W, DEC, EX_I, EX_R, EX_M, EX_BT, EX_BN, M_LW, M_LR, M_SR, WB_A, WB_L;
      C0    = '0;
      F_R   = cv(1,0,0,1,0,1,0,0,0,2'd0,2'b00,0,0);
      F_W   = cv(1,0,0,0,0,0,0,0,0,2'd0,2'b00,0,0);
      DEC   = cv(0,0,0,0,0,0,0,1,1,2'd1,2'b00,0,0);
      EX_I  = cv(0,0,0,0,0,0,0,0,0,2'd1,2'b10,0,0);
      EX_R  = cv(0,0,0,0,0,0,0,0,0,2'd0,2'b10,0,0);
      EX_M  = cv(0,0,0,0,0,0,0,0,0,2'd1,2'b00,0,0);
      EX_BT = cv(0,0,0,0,0,1,1,0,0,2'd0,2'b01,0,0);
      EX_BN = cv(0,0,0,0,0,0,0,0,0,2'd0,2'b01,0,0);
      M_LW  = cv(1,0,1,0,0,0,0,0,0,2'd0,2'b00,0,0);
      M_LR  = cv(1,0,1,0,1,0,0,0,0,2'd0,2'b00,0,0);
      M_SR  = cv(1,1,1,0,0,0,0,0,0,2'd0,2'b00,0,0);
      WB_A  = cv(0,0,0,0,0,0,0,0,0,2'd0,2'b00,1,0);
      WB_L  = cv(0,0,0,0,0,0,0,0,0,2'd0,2'b00,1,1);

      // addi, load with 2 waits, beq taken/not, store, R-type, blt taken, bgeu not taken
      vt.push_back(mk(AI,3'd0,0,0,0,1,3'd0,C0,2'b00,4'd0));
      vt.push_back(mk(AI,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd0));
      vt.push_back(mk(AI,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd0));
      vt.push_back(mk(AI,3'd0,0,0,0,1,3'd3,EX_I,2'b00,4'd0));
      vt.push_back(mk(AI,3'd0,0,0,0,1,3'd5,WB_A,2'b00,4'd0));
      vt.push_back(mk(LD,3'd2,0,0,0,1,3'd1,F_R,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,1,3'd2,DEC,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,1,3'd3,EX_M,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,0,3'd4,M_LW,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,0,3'd4,M_LW,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,1,3'd4,M_LR,2'b00,4'd1));
      vt.push_back(mk(LD,3'd2,0,0,0,1,3'd5,WB_L,2'b00,4'd1));
      vt.push_back(mk(BR,3'd0,1,0,0,1,3'd1,F_R,2'b00,4'd2));
      vt.push_back(mk(BR,3'd0,1,0,0,1,3'd2,DEC,2'b00,4'd2));
      vt.push_back(mk(BR,3'd0,1,0,0,1,3'd3,EX_BT,2'b00,4'd2));
      vt.push_back(mk(BR,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd3));
      vt.push_back(mk(BR,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd3));
      vt.push_back(mk(BR,3'd0,0,0,0,1,3'd3,EX_BN,2'b00,4'd3));
      vt.push_back(mk(STO,3'd2,0,0,0,1,3'd1,F_R,2'b00,4'd4));
      vt.push_back(mk(STO,3'd2,0,0,0,1,3'd2,DEC,2'b00,4'd4));
      vt.push_back(mk(STO,3'd2,0,0,0,1,3'd3,EX_M,2'b00,4'd4));
      vt.push_back(mk(STO,3'd2,0,0,0,1,3'd4,M_SR,2'b00,4'd4));
      vt.push_back(mk(RT,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd5));
      vt.push_back(mk(RT,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd5));
      vt.push_back(mk(RT,3'd0,0,0,0,1,3'd3,EX_R,2'b00,4'd5));
      vt.push_back(mk(RT,3'd0,0,0,0,1,3'd5,WB_A,2'b00,4'd5));
      vt.push_back(mk(BR,3'd4,0,1,0,1,3'd1,F_R,2'b00,4'd6));
      vt.push_back(mk(BR,3'd4,0,1,0,1,3'd2,DEC,2'b00,4'd6));
      vt.push_back(mk(BR,3'd4,0,1,0,1,3'd3,EX_BT,2'b00,4'd6));
      vt.push_back(mk(BR,3'd7,0,0,1,1,3'd1,F_R,2'b00,4'd7));
      vt.push_back(mk(BR,3'd7,0,0,1,1,3'd2,DEC,2'b00,4'd7));
      vt.push_back(mk(BR,3'd7,0,0,1,1,3'd3,EX_BN,2'b00,4'd7));
      vt.push_back(mk(AI,3'd0,0,0,0,0,3'd1,F_W,2'b00,4'd8));

      rst_n = 1'b0; opcode = AI; funct3 = 3'd0; funct7_5 = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;
      #2;
      chk("reset state", 32'(state), 32'd0);
      chk("reset ctrl", 32'(ctrl), 32'd0);
      chk("reset flags", 32'({illegal, bus_err}), 32'd0);
      chk("reset instret", 32'(instret), 32'd0);
      @(negedge clk);
      do_reset();

      for (int i = 0; i < vt.size(); i++) step(vt[i], "tbl", i);

      // illegal opcode: trap holds for 20 cycles regardless of inputs
      do_reset();
      step(mk(7'h7F,3'd0,0,0,0,1,3'd0,C0,2'b00,4'd0), "ill", 0);
      step(mk(7'h7F,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd0), "ill", 1);
      step(mk(7'h7F,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd0), "ill", 2);
      for (int i = 0; i < 20; i++)
         step(mk(7'h7F,3'd0,1,1,1,1'(i),3'd7,C0,2'b10,4'd0), "ill_hold", i);
      rst_n = 1'b0;
      #1;
      chk("ill reset state", 32'(state), 32'd0);
      chk("ill reset flags", 32'({illegal, bus_err}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // branch with reserved funct3 010 traps
      do_reset();
      step(mk(BR,3'd2,0,0,0,1,3'd0,C0,2'b00,4'd0), "brill", 0);
      step(mk(BR,3'd2,0,0,0,1,3'd1,F_R,2'b00,4'd0), "brill", 1);
      step(mk(BR,3'd2,0,0,0,1,3'd2,DEC,2'b00,4'd0), "brill", 2);
      step(mk(BR,3'd2,0,0,0,1,3'd7,C0,2'b10,4'd0), "brill", 3);

      // fetch timeout: exactly 4 stalled FETCH cycles, then TRAP
      do_reset();
      step(mk(AI,3'd0,0,0,0,0,3'd0,C0,2'b00,4'd0), "fto", 0);
      for (int i = 1; i <= 4; i++) step(mk(AI,3'd0,0,0,0,0,3'd1,F_W,2'b00,4'd0), "fto", i);
      step(mk(AI,3'd0,0,0,0,1,3'd7,C0,2'b01,4'd0), "fto", 5);

      // ready in the 4th cycle beats the timeout
      do_reset();
      step(mk(AI,3'd0,0,0,0,0,3'd0,C0,2'b00,4'd0), "frdy", 0);
      for (int i = 1; i <= 3; i++) step(mk(AI,3'd0,0,0,0,0,3'd1,F_W,2'b00,4'd0), "frdy", i);
      step(mk(AI,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd0), "frdy", 4);
      step(mk(AI,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd0), "frdy", 5);

      // memory-state timeout on a load
      do_reset();
      step(mk(LD,3'd2,0,0,0,1,3'd0,C0,2'b00,4'd0), "mto", 0);
      step(mk(LD,3'd2,0,0,0,1,3'd1,F_R,2'b00,4'd0), "mto", 1);
      step(mk(LD,3'd2,0,0,0,1,3'd2,DEC,2'b00,4'd0), "mto", 2);
      step(mk(LD,3'd2,0,0,0,1,3'd3,EX_M,2'b00,4'd0), "mto", 3);
      for (int i = 4; i <= 7; i++) step(mk(LD,3'd2,0,0,0,0,3'd4,M_LW,2'b00,4'd0), "mto", i);
      step(mk(LD,3'd2,0,0,0,0,3'd7,C0,2'b01,4'd0), "mto", 8);

      // reset in the middle of a stalled load drops mem_req at once
      do_reset();
      step(mk(AI,3'd0,0,0,0,1,3'd0,C0,2'b00,4'd0), "mid", 0);
      step(mk(AI,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'd0), "mid", 1);
      step(mk(AI,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'd0), "mid", 2);
      step(mk(AI,3'd0,0,0,0,1,3'd3,EX_I,2'b00,4'd0), "mid", 3);
      step(mk(AI,3'd0,0,0,0,1,3'd5,WB_A,2'b00,4'd0), "mid", 4);
      step(mk(LD,3'd2,0,0,0,1,3'd1,F_R,2'b00,4'd1), "mid", 5);
      step(mk(LD,3'd2,0,0,0,1,3'd2,DEC,2'b00,4'd1), "mid", 6);
      step(mk(LD,3'd2,0,0,0,1,3'd3,EX_M,2'b00,4'd1), "mid", 7);
      mem_ready = 1'b0;
      #1;
      chk("mid mem_req before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid mem_req after", 32'(mem_req), 32'd0);
      chk("mid state", 32'(state), 32'd0);
      chk("mid instret", 32'(instret), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 17 addi instructions wrap a 4-bit counter to 1
      do_reset();
      step(mk(AI,3'd0,0,0,0,1,3'd0,C0,2'b00,4'd0), "wrap", 0);
      for (int k = 0; k < 17; k++) begin
         step(mk(AI,3'd0,0,0,0,1,3'd1,F_R,2'b00,4'(k)), "wrapF", k);
         step(mk(AI,3'd0,0,0,0,1,3'd2,DEC,2'b00,4'(k)), "wrapD", k);
         step(mk(AI,3'd0,0,0,0,1,3'd3,EX_I,2'b00,4'(k)), "wrapE", k);
         step(mk(AI,3'd0,0,0,0,1,3'd5,WB_A,2'b00,4'(k)), "wrapW", k);
      end
      #1;
      chk("wrap final instret", 32'(instret), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
